rv32i_mc_control: RTL and testbench

- Multi-cycle control FSM that sequences the existing rv32i ALU, sign_extend and regfile datapath, with one shared instruction/data memory port.
- Decodes the instruction register and drives alu_ctrl/alu_src/imm_src, register write-back, PC update and memory request strobes state by state.
- Supported instructions: LOAD, STORE, OP, OP-IMM, LUI and BEQ.
- Any other opcode stops the core in a fault state.

---
 rtl/rv32i_mc_control.sv | 236 +++++++++++++++++++++++
 tb/tb_rv32i_mc_control.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/rv32i_mc_control.sv
// Multi-cycle control FSM for the rv32i datapath with a shared instruction/data memory port.
// Define RV32I_MC_INSTRET_EN to add the retired-instruction counter output instret.
module rv32i_mc_control #(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic        alu_zero,
  input  logic        mem_ready,
  output logic        ir_write,
  output logic        pc_write,
  output logic        pc_src,
  output logic        mem_req,
  output logic        mem_we,
  output logic        mem_addr_sel,
  output logic [3:0]  alu_ctrl,
  output logic        alu_src,
  output logic        alu_a_zero,
  output logic [2:0]  imm_src,
  output logic        reg_write,
  output logic        wb_sel,
  output logic        fault,
  output logic [2:0]  state
`ifdef RV32I_MC_INSTRET_EN
  ,
  output logic [31:0] instret
`endif
);

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_SLL  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_SLT  = 4'd8;
  localparam logic [3:0] ALU_SLTU = 4'd9;
  localparam logic [3:0] ALU_NOP  = 4'd15;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [2:0] IMM_I    = 3'b000;
  localparam logic [2:0] IMM_S    = 3'b001;
  localparam logic [2:0] IMM_B    = 3'b010;
  localparam logic [2:0] IMM_U    = 3'b011;
  localparam logic [2:0] IMM_NONE = 3'b111;

  localparam logic [7:0] TIMEOUT_LAST = 8'(MEM_TIMEOUT - 1);

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM_RD = 3'd3,
    ST_MEM_WR = 3'd4,
    ST_WB     = 3'd5,
    ST_FAULT  = 3'd6
  } state_t;

  state_t     state_reg, state_next;
  logic [7:0] timeout_cnt_reg, timeout_cnt_next;
  logic       mem_wait;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7_5;
  logic       supported;
  logic       unused_instr;

  assign opcode       = instr[6:0];
  assign funct3       = instr[14:12];
  assign funct7_5     = instr[30];
  assign unused_instr = ^{instr[31], instr[29:15], instr[11:7]};

  assign supported = (opcode == OPC_LOAD) || (opcode == OPC_STORE) || (opcode == OPC_OP) ||
                     (opcode == OPC_OP_IMM) || (opcode == OPC_LUI) ||
                     ((opcode == OPC_BRANCH) && (funct3 == 3'b000));

  // Shared funct3 decode; alt selects SUB/SRA where the encoding allows it.
  function automatic logic [3:0] alu_op(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  alu_op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  alu_op = ALU_SLL;
      3'b010:  alu_op = ALU_SLT;
      3'b011:  alu_op = ALU_SLTU;
      3'b100:  alu_op = ALU_XOR;
      3'b101:  alu_op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  alu_op = ALU_OR;
      default: alu_op = ALU_AND;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= ST_FETCH;
      timeout_cnt_reg <= 8'd0;
    end else begin
      state_reg       <= state_next;
      timeout_cnt_reg <= timeout_cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    mem_wait   = 1'b0;
    case (state_reg)
      ST_FETCH: begin
        mem_wait = 1'b1;
        if (mem_ready) state_next = ST_DECODE;
      end
      ST_DECODE: state_next = supported ? ST_EXEC : ST_FAULT;
      ST_EXEC: begin
        case (opcode)
          OPC_LOAD:                     state_next = ST_MEM_RD;
          OPC_STORE:                    state_next = ST_MEM_WR;
          OPC_BRANCH:                   state_next = ST_FETCH;
          OPC_OP, OPC_OP_IMM, OPC_LUI:  state_next = ST_WB;
          default:                      state_next = ST_FAULT;
        endcase
      end
      ST_MEM_RD: begin
        mem_wait = 1'b1;
        if (mem_ready) state_next = ST_WB;
      end
      ST_MEM_WR: begin
        mem_wait = 1'b1;
        if (mem_ready) state_next = ST_FETCH;
      end
      ST_WB:    state_next = ST_FETCH;
      default:  state_next = ST_FAULT;
    endcase

    // A completion on the last allowed cycle still wins over the timeout.
    if (mem_wait && !mem_ready && (timeout_cnt_reg == TIMEOUT_LAST)) state_next = ST_FAULT;

    if (state_next != state_reg)    timeout_cnt_next = 8'd0;
    else if (mem_wait && !mem_ready) timeout_cnt_next = timeout_cnt_reg + 8'd1;
    else                             timeout_cnt_next = 8'd0;
  end

  always_comb begin
    ir_write     = 1'b0;
    pc_write     = 1'b0;
    pc_src       = 1'b0;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = 1'b0;
    alu_ctrl     = ALU_NOP;
    alu_src      = 1'b0;
    alu_a_zero   = 1'b0;
    imm_src      = IMM_NONE;
    reg_write    = 1'b0;
    wb_sel       = 1'b0;
    fault        = 1'b0;
    state        = rst ? ST_FETCH : state_reg;
    if (!rst) begin
      case (state_reg)
        ST_FETCH: begin
          mem_req = 1'b1;
          if (mem_ready) begin
            ir_write = 1'b1;
            pc_write = 1'b1;
          end
        end
        ST_EXEC: begin
          case (opcode)
            OPC_LOAD, OPC_STORE: begin
              alu_ctrl = ALU_ADD;
              alu_src  = 1'b1;
              imm_src  = (opcode == OPC_LOAD) ? IMM_I : IMM_S;
            end
            OPC_OP: alu_ctrl = alu_op(funct3, funct7_5);
            OPC_OP_IMM: begin
              alu_ctrl = alu_op(funct3, funct7_5 && (funct3 == 3'b101));
              alu_src  = 1'b1;
              imm_src  = IMM_I;
            end
            OPC_LUI: begin
              alu_ctrl   = ALU_ADD;
              alu_a_zero = 1'b1;
              alu_src    = 1'b1;
              imm_src    = IMM_U;
            end
            OPC_BRANCH: begin
              alu_ctrl = ALU_SUB;
              imm_src  = IMM_B;
              pc_write = alu_zero;
              pc_src   = 1'b1;
            end
            default: ;
          endcase
        end
        ST_MEM_RD: begin
          mem_req      = 1'b1;
          mem_addr_sel = 1'b1;
        end
        ST_MEM_WR: begin
          mem_req      = 1'b1;
          mem_we       = 1'b1;
          mem_addr_sel = 1'b1;
        end
        ST_WB: begin
          reg_write = 1'b1;
          wb_sel    = (opcode == OPC_LOAD);
        end
        ST_FAULT: fault = 1'b1;
        default: ;
      endcase
    end
  end

`ifdef RV32I_MC_INSTRET_EN
  logic [31:0] instret_reg;
  logic        retire;

  assign retire = (state_reg == ST_WB) ||
                  ((state_reg == ST_MEM_WR) && mem_ready) ||
                  ((state_reg == ST_EXEC) && (opcode == OPC_BRANCH));

  always_ff @(posedge clk) begin
    if (rst)         instret_reg <= 32'd0;
    else if (retire) instret_reg <= instret_reg + 32'd1;
  end

  assign instret = instret_reg;
`endif

endmodule

// File: tb/tb_rv32i_mc_control.sv
// Bench for rv32i_mc_control: per-cycle output checks against a phase-sequence model of each instruction.
module tb_rv32i_mc_control;
  localparam int TO = 4;

  localparam logic [2:0] S_F = 3'd0, S_D = 3'd1, S_E = 3'd2, S_MR = 3'd3,
                         S_MW = 3'd4, S_WB = 3'd5, S_FLT = 3'd6;
  localparam logic [3:0] A_ADD = 4'd0, A_SUB = 4'd1, A_AND = 4'd2, A_OR = 4'd3,
                         A_XOR = 4'd4, A_SLL = 4'd5, A_SRL = 4'd6, A_SRA = 4'd7,
                         A_SLT = 4'd8, A_SLTU = 4'd9, A_NOP = 4'd15;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] instr = 32'h0;
  logic        alu_zero = 1'b0;
  logic        mem_ready = 1'b0;
  logic        ir_write, pc_write, pc_src, mem_req, mem_we, mem_addr_sel;
  logic [3:0]  alu_ctrl;
  logic        alu_src, alu_a_zero;
  logic [2:0]  imm_src;
  logic        reg_write, wb_sel, fault;
  logic [2:0]  state;
`ifdef RV32I_MC_INSTRET_EN
  logic [31:0] instret;
`endif

  int tests = 0;
  int failed = 0;
  int unsigned exp_instret = 0;

  always #5 clk = ~clk;

  rv32i_mc_control #(.MEM_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .instr(instr), .alu_zero(alu_zero), .mem_ready(mem_ready),
    .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr_sel(mem_addr_sel), .alu_ctrl(alu_ctrl), .alu_src(alu_src),
    .alu_a_zero(alu_a_zero), .imm_src(imm_src), .reg_write(reg_write), .wb_sel(wb_sel),
    .fault(fault), .state(state)
`ifdef RV32I_MC_INSTRET_EN
    , .instret(instret)
`endif
  );

  logic [20:0] obs;
  assign obs = {ir_write, pc_write, pc_src, mem_req, mem_we, mem_addr_sel, alu_ctrl,
                alu_src, alu_a_zero, imm_src, reg_write, wb_sel, fault, state};

  localparam logic [20:0] IDLE = {6'b0, A_NOP, 2'b0, 3'b111, 3'b0, S_F};

  function automatic logic is_legal(input logic [31:0] ins);
    case (ins[6:0])
      7'h03, 7'h23, 7'h33, 7'h13, 7'h37: is_legal = 1'b1;
      7'h63:   is_legal = (ins[14:12] == 3'b000);
      default: is_legal = 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] alu_of(input logic [2:0] f3, input logic alt);
    logic [3:0] tab [8];
    tab = '{A_ADD, A_SLL, A_SLT, A_SLTU, A_XOR, A_SRL, A_OR, A_AND};
    if (alt && f3 == 3'd0) return A_SUB;
    if (alt && f3 == 3'd5) return A_SRA;
    return tab[f3];
  endfunction

  // Expected output vector for one cycle of a given phase.
  function automatic logic [20:0] expv(input logic [2:0] st, input logic [31:0] ins,
                                       input logic rdy, input logic z);
    logic irw, pcw, pcs, req, we, asel, asrc, az, rw, wbs, flt;
    logic [3:0] alu;
    logic [2:0] imm;
    {irw, pcw, pcs, req, we, asel, asrc, az, rw, wbs, flt} = '0;
    alu = A_NOP;
    imm = 3'b111;
    case (st)
      S_F: begin req = 1; irw = rdy; pcw = rdy; end
      S_E: case (ins[6:0])
        7'h03: begin alu = A_ADD; asrc = 1; imm = 3'b000; end
        7'h23: begin alu = A_ADD; asrc = 1; imm = 3'b001; end
        7'h33: alu = alu_of(ins[14:12], ins[30]);
        7'h13: begin alu = alu_of(ins[14:12], ins[30] && ins[14:12] == 3'd5); asrc = 1; imm = 3'b000; end
        7'h37: begin alu = A_ADD; az = 1; asrc = 1; imm = 3'b011; end
        7'h63: begin alu = A_SUB; imm = 3'b010; pcw = z; pcs = 1; end
        default: ;
      endcase
      S_MR: begin req = 1; asel = 1; end
      S_MW: begin req = 1; we = 1; asel = 1; end
      S_WB: begin rw = 1; wbs = (ins[6:0] == 7'h03); end
      S_FLT: flt = 1;
      default: ;
    endcase
    return {irw, pcw, pcs, req, we, asel, alu, asrc, az, imm, rw, wbs, flt, st};
  endfunction

  // One clock: drive mem_ready after the edge, compare on the falling edge.
  task automatic cyc(input logic rdy, input logic [20:0] e, input string tag, input int idx);
    mem_ready = rdy;
    @(negedge clk);
    tests++;
    assert (obs === e) else begin
      failed++;
      $error("FAIL %s cyc%0d: observed %h expected %h", tag, idx, obs, e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_instret(input string tag);
`ifdef RV32I_MC_INSTRET_EN
    tests++;
    assert (instret === exp_instret) else begin
      failed++;
      $error("FAIL %s instret: observed %0d expected %0d", tag, instret, exp_instret);
    end
`endif
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    cyc(1'($urandom_range(0, 1)), IDLE, tag, 0);
    rst = 1'b0;
    exp_instret = 0;
    check_instret(tag);
  endtask

  // Build the phase sequence an instruction should follow, then replay it against the DUT.
  task automatic run_instr(input logic [31:0] ins, input int wf, input int wm, input logic z,
                           input string tag);
    logic [2:0] sq[$];
    logic       rq[$];
    logic       flt_exp;
    logic [2:0] mst;
    flt_exp = 1'b0;
    for (int i = 0; i < wf && i < TO; i++) begin sq.push_back(S_F); rq.push_back(1'b0); end
    if (wf >= TO) flt_exp = 1'b1;
    else begin sq.push_back(S_F); rq.push_back(1'b1); end
    if (!flt_exp) begin
      sq.push_back(S_D); rq.push_back(1'($urandom_range(0, 1)));
      if (!is_legal(ins)) flt_exp = 1'b1;
      else begin
        sq.push_back(S_E); rq.push_back(1'($urandom_range(0, 1)));
        if (ins[6:0] == 7'h03 || ins[6:0] == 7'h23) begin
          mst = (ins[6:0] == 7'h03) ? S_MR : S_MW;
          for (int i = 0; i < wm && i < TO; i++) begin sq.push_back(mst); rq.push_back(1'b0); end
          if (wm >= TO) flt_exp = 1'b1;
          else begin sq.push_back(mst); rq.push_back(1'b1); end
          if (!flt_exp && mst == S_MR) begin sq.push_back(S_WB); rq.push_back(1'($urandom_range(0, 1))); end
        end else if (ins[6:0] != 7'h63) begin
          sq.push_back(S_WB); rq.push_back(1'($urandom_range(0, 1)));
        end
      end
    end
    if (flt_exp) for (int i = 0; i < 3; i++) begin sq.push_back(S_FLT); rq.push_back(1'($urandom_range(0, 1))); end
    instr = ins;
    alu_zero = z;
    for (int i = 0; i < sq.size(); i++) cyc(rq[i], expv(sq[i], ins, rq[i], z), tag, i + 1);
    if (flt_exp) do_reset({tag, "_rst"});
    else begin
      exp_instret++;
      check_instret(tag);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ins;
    logic [6:0]  opc_tab [8];
    int          sel;
    opc_tab = '{7'h03, 7'h23, 7'h33, 7'h13, 7'h37, 7'h63, 7'h63, 7'h00};

    @(posedge clk);
    #1;
    do_reset("reset");

    run_instr(32'h00500093, 0, 0, 1'b0, "addi");
    run_instr(32'h0000A103, 0, 2, 1'b0, "lw_wait2");
    run_instr(32'h0020A223, 0, 0, 1'b0, "sw");
    run_instr(32'h40208133, 0, 0, 1'b0, "sub");
    run_instr(32'h00000463, 0, 0, 1'b1, "beq_taken");
    run_instr(32'h00000463, 0, 0, 1'b0, "beq_not");
    run_instr(32'h4020D093, 1, 0, 1'b0, "srai");
    run_instr(32'h123450B7, 0, 0, 1'b0, "lui");
    run_instr(32'h00500093, TO - 1, 0, 1'b0, "fetch_last_wait");
    run_instr(32'h0020A223, 0, TO - 1, 1'b0, "mw_last_wait");
    run_instr(32'h0000007F, 0, 0, 1'b0, "illegal");
    run_instr(32'h00001463, 0, 0, 1'b0, "bne_fault");
    run_instr(32'h00500093, TO, 0, 1'b0, "fetch_timeout");
    run_instr(32'h0000A103, 0, TO, 1'b0, "mr_timeout");

    // Reset in the middle of a stalled store: idle during rst, clean FETCH after.
    instr = 32'h0020A223;
    cyc(1'b1, expv(S_F, instr, 1'b1, 1'b0), "rst_mw", 1);
    cyc(1'b0, expv(S_D, instr, 1'b0, 1'b0), "rst_mw", 2);
    cyc(1'b0, expv(S_E, instr, 1'b0, 1'b0), "rst_mw", 3);
    cyc(1'b0, expv(S_MW, instr, 1'b0, 1'b0), "rst_mw", 4);
    rst = 1'b1;
    cyc(1'b0, IDLE, "rst_mw_idle", 5);
    rst = 1'b0;
    exp_instret = 0;
    cyc(1'b0, expv(S_F, instr, 1'b0, 1'b0), "rst_mw_fetch", 6);
    check_instret("rst_mw");
    do_reset("resync");

    for (int k = 0; k < 3; k++) run_instr(32'h00500093, 0, 0, 1'b0, "addi_cnt");

    for (int n = 0; n < 60; n++) begin
      sel = $urandom_range(0, 7);
      ins = $urandom;
      ins[6:0] = (sel == 7) ? 7'($urandom_range(0, 127)) : opc_tab[sel];
      if (sel == 5) ins[14:12] = 3'b000;
      run_instr(ins,
                ($urandom_range(0, 15) == 0) ? TO : $urandom_range(0, TO - 1),
                ($urandom_range(0, 15) == 0) ? TO : $urandom_range(0, TO - 1),
                1'($urandom_range(0, 1)), "rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
